// File: rtl/prefetch_ip_queue_if.sv
// prefetch_ip_queue_if: signals between the prefetch queue, the decoder and the fetch bus.
// master is the queue side, slave is the decoder/bus side.
interface prefetch_ip_queue_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  load;
    logic [ADDR_WIDTH-1:0] load_val;
    logic [ADDR_WIDTH-1:0] ip;
    logic                  byte_valid;
    logic [7:0]            byte_out;
    logic                  byte_pop;
    logic                  mem_access;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [15:0]           mem_data;

    modport master (
        input  load, load_val, byte_pop, mem_ack, mem_data,
        output ip, byte_valid, byte_out, mem_access, mem_addr
    );

    modport slave (
        output load, load_val, byte_pop, mem_ack, mem_data,
        input  ip, byte_valid, byte_out, mem_access, mem_addr
    );
endinterface

// File: rtl/prefetch_ip_queue.sv
// prefetch_ip_queue: instruction pointer with a DEPTH-byte prefetch FIFO fed by 16-bit bus words.
// A load flushes the queue and redirects fetching; an in-flight access is finished and dropped.
module prefetch_ip_queue #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 6
) (
    input logic               clk,
    input logic               reset,
    prefetch_ip_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         count, count_next, space, space_next;
    logic [PW-1:0]         head, tail;
    logic [ADDR_WIDTH-1:0] ip, fetch_addr, fetch_next, req_addr;
    logic [1:0]            need, need_next, pushes;
    logic                  pop, push, byte_valid;
    logic [7:0]            q [DEPTH];

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] n);
        int s;
        s = int'(p) + int'(n);
        return PW'(s >= DEPTH ? s - DEPTH : s);
    endfunction

    assign byte_valid = count != '0;
    assign need       = fetch_addr[0] ? 2'd1 : 2'd2;
    assign pop        = bus.byte_pop && byte_valid && !bus.load;
    assign push       = state == FETCH && bus.mem_ack && !bus.load;
    assign pushes     = push ? need : 2'd0;
    assign count_next = bus.load ? '0 : count + CW'(pushes) - CW'(pop);
    assign fetch_next = bus.load ? bus.load_val : fetch_addr + ADDR_WIDTH'(pushes);
    assign need_next  = fetch_next[0] ? 2'd1 : 2'd2;
    assign space      = DEPTH_C - count;
    assign space_next = DEPTH_C - count_next;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (!bus.load && space >= CW'(need)) ? FETCH : IDLE;
            FETCH:   state_next = bus.load    ? (bus.mem_ack ? IDLE : DISCARD) :
                                  bus.mem_ack ? (space_next >= CW'(need_next) ? FETCH : IDLE) : FETCH;
            DISCARD: state_next = bus.mem_ack ? IDLE : DISCARD;
            default: state_next = IDLE;
        endcase
    end

    // req_addr freezes while an abandoned access drains so the bus sees a stable address
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            count      <= '0;
            ip         <= '0;
            fetch_addr <= '0;
            req_addr   <= '0;
            head       <= '0;
            tail       <= '0;
        end else begin
            count      <= count_next;
            fetch_addr <= fetch_next;
            ip         <= bus.load ? bus.load_val : ip + ADDR_WIDTH'(pop);
            head       <= bus.load ? '0 : pop ? wrap_add(head, 2'd1) : head;
            tail       <= bus.load ? '0 : wrap_add(tail, pushes);
            req_addr   <= state_next == DISCARD ? req_addr : fetch_next;
        end

    always_ff @(posedge clk)
        if (push) begin
            q[tail] <= fetch_addr[0] ? bus.mem_data[15:8] : bus.mem_data[7:0];
            if (!fetch_addr[0]) q[wrap_add(tail, 2'd1)] <= bus.mem_data[15:8];
        end

    assign bus.ip         = ip;
    assign bus.byte_valid = byte_valid;
    assign bus.byte_out   = byte_valid ? q[head] : 8'h00;
    assign bus.mem_access = state != IDLE;
    assign bus.mem_addr   = {req_addr[ADDR_WIDTH-1:1], 1'b0};
endmodule

// File: tb/tb_prefetch_ip_queue.sv
// tb_prefetch_ip_queue: directed scenarios with a byte scoreboard filled on each acked word
// and drained on each pop, plus model-tracked ip and fetch address.
module tb_prefetch_ip_queue;
    logic clk = 0;
    logic reset = 1;
    int   tests = 0;
    int   failed = 0;

    logic [7:0]  sb [$];
    logic [15:0] exp_ip = '0;
    logic [15:0] exp_fetch = '0;

    prefetch_ip_queue_if #(.ADDR_WIDTH(16)) bus ();

    prefetch_ip_queue #(.ADDR_WIDTH(16), .DEPTH(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return {lo + 8'd1, lo};
    endfunction

    task automatic wait_req;
        int n = 0;
        while (!bus.mem_access && n < 20) begin
            tick;
            n++;
        end
        check("req_seen", bus.mem_access, 1);
    endtask

    task automatic serve(input logic [15:0] data);
        wait_req;
        check("mem_addr", bus.mem_addr, {exp_fetch[15:1], 1'b0});
        bus.mem_ack = 1;
        bus.mem_data = data;
        tick;
        bus.mem_ack = 0;
        if (!exp_fetch[0]) begin
            sb.push_back(data[7:0]);
            sb.push_back(data[15:8]);
            exp_fetch += 2;
        end else begin
            sb.push_back(data[15:8]);
            exp_fetch += 1;
        end
        check("valid_after_ack", bus.byte_valid, 1);
        check("head_after_ack", bus.byte_out, sb[0]);
    endtask

    task automatic pop_byte;
        logic [7:0] eb = 8'h00;
        if (sb.size() != 0) eb = sb.pop_front();
        check("pop_valid", bus.byte_valid, 1);
        check("pop_byte", bus.byte_out, eb);
        check("ip_before_pop", bus.ip, exp_ip);
        bus.byte_pop = 1;
        tick;
        bus.byte_pop = 0;
        exp_ip++;
        check("ip_after_pop", bus.ip, exp_ip);
    endtask

    task automatic load_ack(input logic [15:0] val, input logic [15:0] data);
        bus.load = 1;
        bus.load_val = val;
        bus.mem_ack = 1;
        bus.mem_data = data;
        tick;
        bus.load = 0;
        bus.mem_ack = 0;
        sb.delete();
        exp_ip = val;
        exp_fetch = val;
        check("load_ack_ip", bus.ip, val);
        check("load_ack_valid", bus.byte_valid, 0);
        check("load_ack_idle", bus.mem_access, 0);
    endtask

    initial begin
        bus.load = 0;
        bus.load_val = '0;
        bus.byte_pop = 0;
        bus.mem_ack = 0;
        bus.mem_data = '0;
        tick;
        check("rst_ip", bus.ip, 0);
        check("rst_valid", bus.byte_valid, 0);
        check("rst_byte", bus.byte_out, 0);
        check("rst_access", bus.mem_access, 0);
        check("rst_addr", bus.mem_addr, 0);
        reset = 0;

        // fill the queue to capacity, then drain it
        for (int a = 0; a < 6; a += 2) serve(word_at(16'(a)));
        check("full_idle", bus.mem_access, 0);
        for (int i = 0; i < 6; i++) pop_byte;
        check("drained", bus.byte_valid, 0);
        wait_req;
        check("refetch_addr", bus.mem_addr, 16'h0006);

        // reset withdraws the pending request immediately
        reset = 1;
        #1;
        check("async_rst_access", bus.mem_access, 0);
        check("async_rst_ip", bus.ip, 0);
        tick;
        reset = 0;
        sb.delete();
        exp_ip = '0;
        exp_fetch = '0;

        // load while an access is pending with a delayed ack
        serve(word_at(16'h0000));
        serve(word_at(16'h0002));
        wait_req;
        check("pend_addr", bus.mem_addr, 16'h0004);
        bus.load = 1;
        bus.load_val = 16'h2000;
        tick;
        bus.load = 0;
        check("disc_ip", bus.ip, 16'h2000);
        check("disc_valid", bus.byte_valid, 0);
        for (int i = 0; i < 3; i++) begin
            check("disc_access", bus.mem_access, 1);
            check("disc_addr", bus.mem_addr, 16'h0004);
            tick;
        end
        bus.mem_ack = 1;
        bus.mem_data = 16'hDEAD;
        tick;
        bus.mem_ack = 0;
        check("disc_drop_idle", bus.mem_access, 0);
        check("disc_drop_valid", bus.byte_valid, 0);
        sb.delete();
        exp_ip = 16'h2000;
        exp_fetch = 16'h2000;
        wait_req;
        check("redirect_addr", bus.mem_addr, 16'h2000);

        // load to an odd address, coinciding with an ack that must be dropped
        load_ack(16'h0101, 16'h5555);
        serve(16'hAB11);
        check("odd_next_access", bus.mem_access, 1);
        check("odd_next_addr", bus.mem_addr, 16'h0102);
        pop_byte;

        // pop and ack in the same cycle, then refill once space reopens
        serve(word_at(16'h0102));
        serve(word_at(16'h0104));
        wait_req;
        check("pa_addr", bus.mem_addr, 16'h0106);
        check("pa_byte", bus.byte_out, sb.pop_front());
        bus.byte_pop = 1;
        bus.mem_ack = 1;
        bus.mem_data = word_at(16'h0106);
        tick;
        bus.byte_pop = 0;
        bus.mem_ack = 0;
        sb.push_back(8'h06);
        sb.push_back(8'h07);
        exp_fetch += 2;
        exp_ip++;
        check("pa_ip", bus.ip, exp_ip);
        check("pa_idle", bus.mem_access, 0);
        check("pa_head", bus.byte_out, sb[0]);
        pop_byte;
        check("pa_still_idle", bus.mem_access, 0);
        tick;
        check("pa_refetch", bus.mem_access, 1);
        check("pa_refetch_addr", bus.mem_addr, 16'h0108);

        // address wrap at the top of memory
        load_ack(16'hFFFF, 16'h0000);
        serve(16'h7766);
        check("wrap_next_addr", bus.mem_addr, 16'h0000);
        pop_byte;
        check("wrap_ip", bus.ip, 16'h0000);

        // pop on an empty queue, then load together with pop
        bus.byte_pop = 1;
        tick;
        bus.byte_pop = 0;
        check("empty_pop_ip", bus.ip, 16'h0000);
        check("empty_pop_valid", bus.byte_valid, 0);
        serve(word_at(16'h0000));
        bus.load = 1;
        bus.load_val = 16'h4000;
        bus.byte_pop = 1;
        tick;
        bus.load = 0;
        bus.byte_pop = 0;
        check("lp_ip", bus.ip, 16'h4000);
        check("lp_valid", bus.byte_valid, 0);
        check("lp_hold_addr", bus.mem_addr, 16'h0002);
        sb.delete();
        exp_ip = 16'h4000;
        exp_fetch = 16'h4000;
        bus.mem_ack = 1;
        tick;
        bus.mem_ack = 0;
        check("lp_drop_idle", bus.mem_access, 0);
        serve(word_at(16'h4000));
        pop_byte;
        pop_byte;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
